// File: rtl/acc_ingress_buffer.sv
// Ingress buffer between the producer stub and a wrapping accumulator: a FIFO
// absorbs bursts from a producer with no backpressure, counts drops, and supports flush.
module acc_ingress_buffer #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_value,
    input  logic          drain_en,
    input  logic          flush_req,
    output logic [AW-1:0] accumulator,
    output logic          acc_overflow,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   drop_count,
    output logic          flush_busy
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;

    logic [DW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic [AW-1:0]  r_acc;
    logic           r_acc_ovf;
    logic [15:0]    r_drop_cnt;
    logic           r_flush_busy;

    logic           w_empty;
    logic           w_full;
    logic           w_push_allow;
    logic           w_pop_acc;
    logic           w_pop_discard;
    logic           w_flush_done;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [DW-1:0]  w_head;
    logic [AW-1:0]  w_head_ext;
    logic [AW:0]    w_sum;

    assign w_empty    = (r_level == {LW{1'b0}});
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_ext = AW'(w_head);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_head_ext};

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush_req is ignored while already flushing
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush_req) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_empty) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        w_push_allow  = 1'b0;
        w_pop_acc     = 1'b0;
        w_pop_discard = 1'b0;
        w_flush_done  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_push_allow = 1'b1;
                w_pop_acc    = drain_en && !w_empty;
            end
            ST_FLUSH: begin
                w_pop_discard = !w_empty;
                w_flush_done  = w_empty;
            end
            default: begin
                w_push_allow  = 1'b0;
                w_pop_acc     = 1'b0;
                w_pop_discard = 1'b0;
                w_flush_done  = 1'b0;
            end
        endcase
    end

    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_pop  = w_pop_acc || w_pop_discard;
    assign w_push = w_push_allow && in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && !w_push;

    // FIFO storage; not reset
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_value;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Accumulator with sticky carry; cleared when a flush completes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc     <= {AW{1'b0}};
            r_acc_ovf <= 1'b0;
        end else if (w_flush_done) begin
            r_acc     <= {AW{1'b0}};
            r_acc_ovf <= 1'b0;
        end else if (w_pop_acc) begin
            r_acc <= w_sum[AW-1:0];
            if (w_sum[AW]) begin
                r_acc_ovf <= 1'b1;
            end
        end
    end

    // Drop counter and registered busy flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt   <= 16'd0;
            r_flush_busy <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
            r_flush_busy <= (w_state_nxt == ST_FLUSH);
        end
    end

    assign accumulator  = r_acc;
    assign acc_overflow = r_acc_ovf;
    assign fifo_level   = r_level;
    assign drop_count   = r_drop_cnt;
    assign flush_busy   = r_flush_busy;

endmodule

// File: tb/tb_acc_ingress_buffer.sv
// Randomized and directed bench for acc_ingress_buffer, checked against a
// queue-based behavioural model of the buffer and accumulator.
module tb_acc_ingress_buffer;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_value;
    logic          drain_en;
    logic          flush_req;
    logic [AW-1:0] accumulator;
    logic          acc_overflow;
    logic [LW-1:0] fifo_level;
    logic [15:0]   drop_count;
    logic          flush_busy;

    acc_ingress_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_value     (in_value),
        .drain_en     (drain_en),
        .flush_req    (flush_req),
        .accumulator  (accumulator),
        .acc_overflow (acc_overflow),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .flush_busy   (flush_busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_q[$];
    longint      m_acc;
    bit          m_ovf;
    int          m_drop;
    bit          m_flushing;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_acc      = 0;
        m_ovf      = 0;
        m_drop     = 0;
        m_flushing = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] val, input bit drn, input bit fl);
        int     size0;
        bit     pop;
        bit     push;
        longint sum;
        size0 = m_q.size();
        pop   = (size0 > 0) && (m_flushing || drn);
        push  = !m_flushing && v && (size0 < DEPTH || pop);
        if (pop) begin
            sum = longint'(m_q.pop_front());
            if (!m_flushing) begin
                sum = m_acc + sum;
                if (sum >= 64'h1_0000_0000) m_ovf = 1;
                m_acc = sum % 64'h1_0000_0000;
            end
        end
        if (push) m_q.push_back(val);
        else if (v && m_drop < 65535) m_drop++;
        if (m_flushing) begin
            if (size0 == 0) begin
                m_flushing = 0;
                m_acc      = 0;
                m_ovf      = 0;
            end
        end else if (fl) begin
            m_flushing = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".acc"},   accumulator,  m_acc);
        check_eq({tag, ".ovf"},   acc_overflow, m_ovf);
        check_eq({tag, ".level"}, fifo_level,   m_q.size());
        check_eq({tag, ".drops"}, drop_count,   m_drop);
        check_eq({tag, ".busy"},  flush_busy,   m_flushing);
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] val,
                        input bit drn, input bit fl);
        in_valid  = v;
        in_value  = val;
        drain_en  = drn;
        flush_req = fl;
        @(posedge clock);
        model_step(v, val, drn, fl);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        in_valid  = 1'b0;
        drain_en  = 1'b0;
        flush_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        drain_en  = 1'b0;
        flush_req = 1'b0;
        model_reset();
        #12;
        check_all("rst");
        @(negedge clock);
        reset = 1'b0;

        // Basic drain-through
        step("t1", 1'b1, 32'd1, 1'b1, 1'b0);
        step("t1", 1'b1, 32'd2, 1'b1, 1'b0);
        check_eq("t1.acc_e2", accumulator, 32'd1);
        step("t1", 1'b1, 32'd3, 1'b1, 1'b0);
        check_eq("t1.acc_e3", accumulator, 32'd3);
        step("t1", 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t1.acc_e4", accumulator, 32'd6);

        // Overfill then drain
        apply_reset("t2rst");
        for (int i = 0; i < 10; i++) step("t2fill", 1'b1, 32'd5, 1'b0, 1'b0);
        check_eq("t2.level", fifo_level, 8);
        check_eq("t2.drops", drop_count, 2);
        for (int i = 0; i < 8; i++) step("t2drain", 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t2.acc", accumulator, 32'd40);

        // Accumulator wrap
        apply_reset("t3rst");
        step("t3", 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
        step("t3", 1'b1, 32'h0000_0020, 1'b1, 1'b0);
        step("t3", 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t3.acc", accumulator, 32'h10);
        check_eq("t3.ovf", acc_overflow, 1'b1);
        step("t3", 1'b1, 32'd7, 1'b1, 1'b0);
        step("t3", 1'b0, 32'd0, 1'b1, 1'b0);
        check_eq("t3.ovf_sticky", acc_overflow, 1'b1);

        // Flush with 5 entries; valids during flush are drops
        for (int i = 0; i < 5; i++) step("t4fill", 1'b1, $urandom, 1'b0, 1'b0);
        step("t4req", 1'b0, 32'd0, 1'b0, 1'b1);
        guard = 0;
        while (m_flushing && guard < 20) begin
            step("t4fl", 1'b1, $urandom, 1'b0, 1'b1);
            guard++;
        end
        check_eq("t4.busy_cycles", guard, 6);
        check_eq("t4.acc", accumulator, 32'd0);
        check_eq("t4.ovf", acc_overflow, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) step("t5fill", 1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("t5", 1'b1, $urandom, 1'b1, 1'b0);
        check_eq("t5.level", fifo_level, 8);

        // Reset mid-flush and mid-burst
        for (int i = 0; i < 6; i++) step("t6fill", 1'b1, $urandom, 1'b0, 1'b0);
        step("t6req", 1'b0, 32'd0, 1'b0, 1'b1);
        step("t6fl", 1'b0, 32'd0, 1'b0, 1'b0);
        apply_reset("t6rst_fl");
        for (int i = 0; i < 4; i++) step("t6b", 1'b1, $urandom, 1'b1, 1'b0);
        apply_reset("t6rst_b");
        step("t6post", 1'b1, 32'd9, 1'b1, 1'b0);
        step("t6post", 1'b0, 32'd0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step("rnd", ($urandom_range(0, 3) != 0), $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
